// File: rtl/risky_pkg.sv
// Shared decode definitions for the ALU issue stage: opcodes, funct fields, ALU codes, entry bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package risky_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b001000;
    localparam logic [5:0] ALU_SLT = 6'b000010;
    localparam logic [5:0] ALU_XOR = 6'b000100;
    localparam logic [5:0] ALU_AND = 6'b000111;

    // One decoded instruction as it travels toward execute.
    typedef struct packed {
        logic [5:0]  alu_ctrl;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal_inst;
    } entry_t;

    // funct3 values shared by R-type (funct7=0) and I-type ALU ops.
    function automatic logic f3_supported(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_XOR) || (f3 == F3_AND);
    endfunction

    function automatic logic [5:0] f3_to_alu(input logic [2:0] f3);
        case (f3)
            F3_SLT:  return ALU_SLT;
            F3_XOR:  return ALU_XOR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of one RV32 instruction plus register data into an entry_t.
// Latency: zero (pure combinational).
// Backpressure: none; the issue stage decides when the result is captured.
module alu_op_decode
    import risky_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output entry_t      entry
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};

    logic        legal;
    logic [5:0]  alu;
    logic [31:0] op_b;
    logic        wr, rd_mem, wr_mem, has_rd;

    // Classify the encoding; anything unmatched stays illegal and issues as an all-zero bundle.
    always_comb begin
        legal  = 1'b0;
        alu    = ALU_ADD;
        op_b   = '0;
        wr     = 1'b0;
        rd_mem = 1'b0;
        wr_mem = 1'b0;
        has_rd = 1'b0;
        entry  = '0;

        case (opcode)
            OP_R: begin
                op_b   = rs2_data;
                wr     = 1'b1;
                has_rd = 1'b1;
                if (funct7 == F7_BASE && f3_supported(funct3)) begin
                    legal = 1'b1;
                    alu   = f3_to_alu(funct3);
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    legal = 1'b1;
                    alu   = ALU_SUB;
                end
            end
            OP_I: begin
                op_b   = imm_i;
                wr     = 1'b1;
                has_rd = 1'b1;
                legal  = f3_supported(funct3);
                alu    = f3_to_alu(funct3);
            end
            OP_LOAD: begin
                op_b   = imm_i;
                wr     = 1'b1;
                rd_mem = 1'b1;
                has_rd = 1'b1;
                legal  = (funct3 == F3_W);
            end
            OP_STORE: begin
                op_b   = imm_s;
                wr_mem = 1'b1;
                legal  = (funct3 == F3_W);
            end
            default: legal = 1'b0;
        endcase

        if (legal) begin
            entry.alu_ctrl   = alu;
            entry.op_a       = rs1_data;
            entry.op_b       = op_b;
            entry.store_data = wr_mem ? rs2_data : 32'd0;
            entry.rd         = has_rd ? instruction[11:7] : 5'd0;
            // Writes to x0 are architecturally dropped.
            entry.reg_write  = wr && (instruction[11:7] != 5'd0);
            entry.mem_read   = rd_mem;
            entry.mem_write  = wr_mem;
        end else begin
            entry.illegal_inst = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: registers decoded ALU entries toward execute (optional skid via ALU_ISSUE_SKID_EN).
// Latency: one cycle from accept to out_valid; one entry per cycle while out_ready is high.
// Backpressure: payload held while stalled; inst_ready combinational (default) or registered !skid_full (skid build).
module alu_issue_stage
    import risky_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] instruction,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  ALU_Control,
    output logic [31:0] operand_A,
    output logic [31:0] operand_B,
    output logic [31:0] store_data,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        illegal_inst
);

    entry_t dec_entry;
    entry_t out_q;
    logic   accept;
    logic   pop;

    alu_op_decode u_decode (
        .instruction (instruction),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .entry       (dec_entry)
    );

    assign pop    = out_valid && out_ready;
    assign accept = inst_valid && inst_ready && !flush;

`ifdef ALU_ISSUE_SKID_EN
    entry_t skid_q;
    logic   skid_full;

    // Ready depends only on flop state, so no combinational path from out_ready.
    assign inst_ready = !reset && !skid_full;

    // Output register plus skid: the skid catches the one entry accepted while output is stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            skid_full <= 1'b0;
            skid_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (!out_valid || pop) begin
            if (skid_full) begin
                // Skid is older than anything arriving now; inst_ready was low so no accept.
                out_q     <= skid_q;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_q     <= dec_entry;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q    <= dec_entry;
            skid_full <= 1'b1;
        end
    end
`else
    assign inst_ready = !reset && (!out_valid || out_ready);

    // Single output register; a pop and an accept in the same cycle replace the entry with no bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_q     <= dec_entry;
            out_valid <= 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`endif

    assign ALU_Control  = out_q.alu_ctrl;
    assign operand_A    = out_q.op_a;
    assign operand_B    = out_q.op_b;
    assign store_data   = out_q.store_data;
    assign rd           = out_q.rd;
    assign reg_write    = out_q.reg_write;
    assign mem_read     = out_q.mem_read;
    assign mem_write    = out_q.mem_write;
    assign illegal_inst = out_q.illegal_inst;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: driver pushes hand-computed entries, monitor pops on transfer.
// Latency: checks one-cycle issue and stable payload under stall.
// Backpressure: exercises stall, skid ready drop, flush and mid-stream reset.
module tb_alu_issue_stage;
    import risky_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal_inst;

    int checks = 0;
    int errors = 0;
    entry_t sb[$];

    always #5 clock = ~clock;

    alu_issue_stage dut (
        .clock        (clock),
        .reset        (reset),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .instruction  (instruction),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ALU_Control  (ALU_Control),
        .operand_A    (operand_A),
        .operand_B    (operand_B),
        .store_data   (store_data),
        .rd           (rd),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .illegal_inst (illegal_inst)
    );

    function automatic entry_t mk(input logic [5:0] alu, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] sd, input logic [4:0] r,
                                  input logic rw, input logic mr, input logic mw, input logic ill);
        entry_t e;
        e.alu_ctrl = alu; e.op_a = a; e.op_b = b; e.store_data = sd; e.rd = r;
        e.reg_write = rw; e.mem_read = mr; e.mem_write = mw; e.illegal_inst = ill;
        return e;
    endfunction

    function automatic entry_t actual();
        return mk(ALU_Control, operand_A, operand_B, store_data, rd,
                  reg_write, mem_read, mem_write, illegal_inst);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_entry(input string name, input entry_t act, input entry_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got alu=%b a=%h b=%h sd=%h rd=%0d rw=%b mr=%b mw=%b ill=%b expected alu=%b a=%h b=%h sd=%h rd=%0d rw=%b mr=%b mw=%b ill=%b",
                     name, act.alu_ctrl, act.op_a, act.op_b, act.store_data, act.rd,
                     act.reg_write, act.mem_read, act.mem_write, act.illegal_inst,
                     exp.alu_ctrl, exp.op_a, exp.op_b, exp.store_data, exp.rd,
                     exp.reg_write, exp.mem_read, exp.mem_write, exp.illegal_inst);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction until accepted; expected entry enters the scoreboard on acceptance.
    task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                        input entry_t exp);
        int n = 0;
        inst_valid  = 1'b1;
        instruction = ins;
        rs1_data    = r1;
        rs2_data    = r2;
        @(negedge clock);
        while (!inst_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!inst_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instruction %h got inst_ready=0 expected 1 within 50 cycles", ins);
        end else begin
            sb.push_back(exp);
        end
        tick();
        inst_valid = 1'b0;
    endtask

    // Monitor: transfers pop and compare; stalled outputs must match the head unchanged.
    always @(negedge clock) begin
        if (!reset && !flush && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out_valid=1 expected no entry pending");
            end else if (out_ready) begin
                check_entry("transfer", actual(), sb.pop_front());
            end else begin
                check_entry("stall_stable", actual(), sb[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; inst_valid = 1'b0; instruction = '0; rs1_data = '0; rs2_data = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_inst_ready", 64'(inst_ready), 64'd0);
        check_entry("rst_payload", actual(), '0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", 64'(inst_ready), 64'd1);
        tick();

        // Back-to-back decode vectors, out_ready held high.
        send(32'h002081B3, 32'd5, 32'd3, mk(ALU_ADD, 32'd5, 32'd3, 32'd0, 5'd3, 1, 0, 0, 0));
        send(32'h402081B3, 32'd5, 32'd3, mk(ALU_SUB, 32'd5, 32'd3, 32'd0, 5'd3, 1, 0, 0, 0));
        send(32'h0020A1B3, 32'd5, 32'd3, mk(ALU_SLT, 32'd5, 32'd3, 32'd0, 5'd3, 1, 0, 0, 0));
        send(32'h0020C1B3, 32'd5, 32'd3, mk(ALU_XOR, 32'd5, 32'd3, 32'd0, 5'd3, 1, 0, 0, 0));
        send(32'h0020F1B3, 32'd5, 32'd3, mk(ALU_AND, 32'd5, 32'd3, 32'd0, 5'd3, 1, 0, 0, 0));
        send(32'hFFF00293, 32'd0, 32'd0, mk(ALU_ADD, 32'd0, 32'hFFFFFFFF, 32'd0, 5'd5, 1, 0, 0, 0));
        send(32'h00F0F293, 32'h1234, 32'd0, mk(ALU_AND, 32'h1234, 32'h0000000F, 32'd0, 5'd5, 1, 0, 0, 0));
        send(32'h8000A193, 32'd7, 32'd0, mk(ALU_SLT, 32'd7, 32'hFFFFF800, 32'd0, 5'd3, 1, 0, 0, 0));
        send(32'h00812303, 32'h100, 32'd9, mk(ALU_ADD, 32'h100, 32'd8, 32'd0, 5'd6, 1, 1, 0, 0));
        send(32'h0070A623, 32'h200, 32'hDEADBEEF,
             mk(ALU_ADD, 32'h200, 32'd12, 32'hDEADBEEF, 5'd0, 0, 0, 1, 0));
        send(32'h0020E1B3, 32'd5, 32'd3, mk(ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1));
        send(32'h4020A1B3, 32'd5, 32'd3, mk(ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1));
        send(32'h00208033, 32'd5, 32'd3, mk(ALU_ADD, 32'd5, 32'd3, 32'd0, 5'd0, 0, 0, 0, 0));
        repeat (2) tick();

        // Stall: out_ready low for several cycles while the producer keeps offering.
        out_ready = 1'b0;
        fork
            begin
                send(32'h0050C213, 32'd1, 32'd0, mk(ALU_XOR, 32'd1, 32'd5, 32'd0, 5'd4, 1, 0, 0, 0));
                send(32'h002081B3, 32'd10, 32'd20, mk(ALU_ADD, 32'd10, 32'd20, 32'd0, 5'd3, 1, 0, 0, 0));
                send(32'h402081B3, 32'd10, 32'd20, mk(ALU_SUB, 32'd10, 32'd20, 32'd0, 5'd3, 1, 0, 0, 0));
            end
            begin
                repeat (4) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        repeat (3) tick();

        // Ready drop under stall.
        out_ready = 1'b0;
        send(32'h002081B3, 32'd1, 32'd2, mk(ALU_ADD, 32'd1, 32'd2, 32'd0, 5'd3, 1, 0, 0, 0));
`ifdef ALU_ISSUE_SKID_EN
        send(32'h0020C1B3, 32'd1, 32'd2, mk(ALU_XOR, 32'd1, 32'd2, 32'd0, 5'd3, 1, 0, 0, 0));
`endif
        @(negedge clock);
        check("ready_drop_stalled", 64'(inst_ready), 64'd0);
        tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // Flush the cycle after an accept, with a competing valid instruction.
        out_ready = 1'b0;
        send(32'h0020F1B3, 32'd3, 32'd4, mk(ALU_AND, 32'd3, 32'd4, 32'd0, 5'd3, 1, 0, 0, 0));
        flush = 1'b1;
        inst_valid = 1'b1;
        instruction = 32'h402081B3;
        sb.delete();
        tick();
        flush = 1'b0;
        inst_valid = 1'b0;
        @(negedge clock);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_inst_ready", 64'(inst_ready), 64'd1);
        tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset mid-stream discards the held entry.
        out_ready = 1'b0;
        send(32'h00812303, 32'h40, 32'd0, mk(ALU_ADD, 32'h40, 32'd8, 32'd0, 5'd6, 1, 1, 0, 0));
        reset = 1'b1;
        sb.delete();
        tick();
        @(negedge clock);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_inst_ready", 64'(inst_ready), 64'd0);
        check_entry("midreset_payload", actual(), '0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        send(32'hFFF00293, 32'd2, 32'd0, mk(ALU_ADD, 32'd2, 32'hFFFFFFFF, 32'd0, 5'd5, 1, 0, 0, 0));
        repeat (4) tick();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
